// File: rtl/bus_arbiter_if.sv
// Bus arbiter interface: groups the request/address and grant/address
// signals shared between two bus masters and the arbiter.
//   m1_req, m2_req   : master bus requests, level-held per transaction
//   m1_addr, m2_addr : master addresses (16 bit)
//   m1_grant, m2_grant : per-master ownership flags from the arbiter
//   msel             : owning master, 0 = master 1 or none, 1 = master 2
//   addr             : address of the owning master, zero when idle
//   bus_busy         : high while either master owns the bus
// Modports: master = request side, slave = arbiter side.
interface bus_arbiter_if;
  logic        m1_req;
  logic        m2_req;
  logic [15:0] m1_addr;
  logic [15:0] m2_addr;
  logic        m1_grant;
  logic        m2_grant;
  logic        msel;
  logic [15:0] addr;
  logic        bus_busy;

  modport master (
    output m1_req, m2_req, m1_addr, m2_addr,
    input  m1_grant, m2_grant, msel, addr, bus_busy
  );

  modport slave (
    input  m1_req, m2_req, m1_addr, m2_addr,
    output m1_grant, m2_grant, msel, addr, bus_busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with bounded hold time.
// A granted master keeps the bus while it requests; once it has held the bus
// for HOLD_MAX cycles a contending master may pre-empt it. Every handover
// passes through one IDLE cycle, so the two grants are never high together.
// Ports:
//   clk : system clock, rising-edge
//   rst : synchronous active-high reset
//   bus : bus_arbiter_if.slave (requests/addresses in, grants/addr out)
// Parameter HOLD_MAX : grant cycles before pre-emption is allowed (2..256).
module bus_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic           clk,
  input  logic           rst,
  bus_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t      state;
  state_t      next_state;
  logic        last_m;      // last granted master: 0 = master 1, 1 = master 2
  logic [7:0]  hold_cnt;    // grant cycles already completed, saturating
  logic        hold_done;
  logic        m1_grant;
  logic        m2_grant;
  logic        msel;
  logic        bus_busy;
  logic [15:0] addr;

  // Next-state decision: idle arbitration, release and pre-emption.
  always_comb begin
    next_state = state;
    hold_done  = (hold_cnt == HOLD_LAST);
    case (state)
      IDLE: begin
        if (bus.m1_req && bus.m2_req) begin
          // Tie: favour the master that did not have the bus last.
          next_state = last_m ? GNT1 : GNT2;
        end else if (bus.m1_req) begin
          next_state = GNT1;
        end else if (bus.m2_req) begin
          next_state = GNT2;
        end else begin
          next_state = IDLE;
        end
      end
      GNT1: begin
        if (!bus.m1_req || (hold_done && bus.m2_req)) begin
          next_state = IDLE;
        end else begin
          next_state = GNT1;
        end
      end
      GNT2: begin
        if (!bus.m2_req || (hold_done && bus.m1_req)) begin
          next_state = IDLE;
        end else begin
          next_state = GNT2;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State, registered grant flags, round-robin memory and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      m1_grant <= 1'b0;
      m2_grant <= 1'b0;
      msel     <= 1'b0;
      bus_busy <= 1'b0;
      hold_cnt <= 8'd0;
      last_m   <= 1'b1;  // master 1 wins the first tie after reset
    end else begin
      state    <= next_state;
      // Outputs are registered from next_state so they track state exactly.
      m1_grant <= (next_state == GNT1);
      m2_grant <= (next_state == GNT2);
      msel     <= (next_state == GNT2);
      bus_busy <= (next_state != IDLE);
      if ((state == IDLE) && (next_state == GNT1)) begin
        last_m <= 1'b0;
      end else if ((state == IDLE) && (next_state == GNT2)) begin
        last_m <= 1'b1;
      end else begin
        last_m <= last_m;
      end
      // Held at zero in IDLE, so each grant starts counting from zero.
      if (state == IDLE) begin
        hold_cnt <= 8'd0;
      end else if (!hold_done) begin
        hold_cnt <= hold_cnt + 8'd1;
      end else begin
        hold_cnt <= hold_cnt;
      end
    end
  end

  // Address mux to the decoder, following the current owner.
  always_comb begin
    addr = 16'h0000;
    case (state)
      GNT1:    addr = bus.m1_addr;
      GNT2:    addr = bus.m2_addr;
      default: addr = 16'h0000;
    endcase
  end

  assign bus.m1_grant = m1_grant;
  assign bus.m2_grant = m2_grant;
  assign bus.msel     = msel;
  assign bus.bus_busy = bus_busy;
  assign bus.addr     = addr;

endmodule
